// File: rtl/arquitetura_cmd_pio_out.sv
`default_nettype none
// ============================================================================
//  Module      : arquitetura_cmd_pio_out
//  Description : Avalon-MM slave command output port. The CPU writes a value
//                that is handed to fabric logic over a valid/ready handshake,
//                with one in-flight value and a one-deep coalescing pending
//                slot. Status and overrun are readable by the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module arquitetura_cmd_pio_out #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [1:0] c_ADDR_DATA     = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS   = 2'd1;
    localparam logic [1:0] c_ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] c_ADDR_OUTCLEAR = 2'd3;

    // SEND: out_port holds an unaccepted value.
    // PEND: additionally, data_reg holds a newer value not yet presented.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   w_nxt;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_port_val;
    logic                    w_port_load;
    logic                    w_set_ovr;
    logic                    w_clr_ovr;
    logic                    r_overrun;
    logic                    w_wr;
    logic                    w_launch;
    logic                    w_acc;
    logic                    w_pending;
    logic [31:0]             w_data_ext;
    logic [31:0]             w_rd_nxt;
    logic                    w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wdata   = writedata[DATA_WIDTH-1:0];
    assign w_launch  = w_wr & (address != c_ADDR_STATUS);
    assign out_valid = (r_state != S_IDLE);
    assign w_pending = (r_state == S_PEND);
    assign w_acc     = out_valid & out_ready;
    assign w_clr_ovr = w_wr & (address == c_ADDR_STATUS) & writedata[2];

    // Bits above DATA_WIDTH are deliberately dropped.
    assign w_unused  = &{1'b0, writedata};

    // Post-write value of the data register for the current bus cycle.
    always_comb begin
        w_nxt = r_data;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:     w_nxt = w_wdata;
                c_ADDR_OUTSET:   w_nxt = r_data | w_wdata;
                c_ADDR_OUTCLEAR: w_nxt = r_data & ~w_wdata;
                default:         w_nxt = r_data;
            endcase
        end
    end

    // Zero-extend the data register for readback; works for DATA_WIDTH == 32 too.
    always_comb begin
        w_data_ext                 = '0;
        w_data_ext[DATA_WIDTH-1:0] = r_data;
    end

    // Read mux, sampled into readdata every clock.
    always_comb begin
        w_rd_nxt = '0;
        case (address)
            c_ADDR_DATA:   w_rd_nxt = w_data_ext;
            c_ADDR_STATUS: w_rd_nxt = {29'b0, r_overrun, w_pending, out_valid};
            default:       w_rd_nxt = '0;
        endcase
    end

    // Handshake FSM next-state and out_port load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_port_load = 1'b0;
        w_port_val  = w_nxt;
        w_set_ovr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_SEND;
                    w_port_load = 1'b1;
                end
            end
            S_SEND: begin
                if (w_acc) begin
                    if (w_launch) begin
                        w_port_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_launch) begin
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (w_acc) begin
                    // The pending value is simply the latest data_reg.
                    w_state_nxt = S_SEND;
                    w_port_load = 1'b1;
                    w_port_val  = w_launch ? w_nxt : r_data;
                end else if (w_launch) begin
                    w_set_ovr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data register follows every launching write regardless of FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
        end else begin
            r_data <= w_nxt;
        end
    end

    // Presented value; only changes when the FSM loads a new one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
        end else if (w_port_load) begin
            out_port <= w_port_val;
        end
    end

    // Sticky overrun flag; a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_set_ovr) begin
            r_overrun <= 1'b1;
        end else if (w_clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    // Registered read data, one-cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_nxt;
        end
    end

endmodule
`default_nettype wire
